// File: rtl/grf_wb.sv
// 32 x 32 general register file with $0 hardwired to zero, optional same-cycle
// write-to-read forwarding, and a one-cycle-delayed write-back trace record.
module grf_wb #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int FWD_EN = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [31:0]   pc,
    output logic          trace_valid,
    output logic [31:0]   trace_pc,
    output logic [AW-1:0] trace_addr,
    output logic [DW-1:0] trace_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] regs [DEPTH];
    logic          wr_hit;

    // A write to $0 is treated as no write at all, for both the array and the trace.
    assign wr_hit = we && (wa != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            if ((FWD_EN != 0) && wr_hit && (wa == ra1)) begin
                rd1 = wd;
            end else begin
                rd1 = regs[ra1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            if ((FWD_EN != 0) && wr_hit && (wa == ra2)) begin
                rd2 = wd;
            end else begin
                rd2 = regs[ra2];
            end
        end
    end

    // Trace payload holds its last value when no write commits; only trace_valid qualifies it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            trace_valid <= wr_hit;
            if (wr_hit) begin
                trace_pc   <= pc;
                trace_addr <= wa;
                trace_data <= wd;
            end
        end
    end

endmodule

// File: tb/tb_grf_wb.sv
// Directed bench for grf_wb: one forwarding instance and one non-forwarding
// instance share all inputs; expected values come from a small register model.
module tb_grf_wb;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, rd1_nf, rd2_nf, wd, pc;
    logic        we;
    logic        trace_valid, trace_valid_nf;
    logic [31:0] trace_pc, trace_data, trace_pc_nf, trace_data_nf;
    logic [4:0]  trace_addr, trace_addr_nf;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int          n_vec;
    int          n_err;

    grf_wb #(.DW(32), .AW(5), .FWD_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .pc(pc),
        .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_addr(trace_addr), .trace_data(trace_data)
    );

    grf_wb #(.DW(32), .AW(5), .FWD_EN(0)) dut_nf (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_nf), .rd2(rd2_nf),
        .we(we), .wa(wa), .wd(wd), .pc(pc),
        .trace_valid(trace_valid_nf), .trace_pc(trace_pc_nf),
        .trace_addr(trace_addr_nf), .trace_data(trace_data_nf)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one write at the falling edge, commit it at the rising edge, then
    // check the trace record against the expected queue.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        @(negedge clk);
        we = 1'b1;
        wa = a;
        wd = d;
        pc = p;
        if (a != 5'd0) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (a != 5'd0) begin
            model[a] = d;
            check("wr_trace_valid", {31'd0, trace_valid}, 32'd1);
            check("wr_trace_pc", trace_pc, p);
            check("wr_trace_addr", {27'd0, trace_addr}, {27'd0, a});
            check("wr_trace_data", trace_data, exp_q.pop_front());
        end
    endtask

    task automatic idle();
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        we      = 1'b0;
        wa      = '0;
        wd      = '0;
        pc      = '0;
        ra1     = '0;
        ra2     = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // reset then read all
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            check("rst_rd1", rd1, 32'd0);
            check("rst_rd2", rd2, 32'd0);
        end
        check("rst_trace_valid", {31'd0, trace_valid}, 32'd0);
        check("rst_trace_pc", trace_pc, 32'd0);
        check("rst_trace_addr", {27'd0, trace_addr}, 32'd0);
        check("rst_trace_data", trace_data, 32'd0);

        // basic write / read
        ra1 = 5'd8;
        do_write(5'd8, 32'h1234_5678, 32'h0000_3000);
        check("basic_rd1", rd1, 32'h1234_5678);
        idle();
        #1;
        check("basic_rd1_stored", rd1_nf, 32'h1234_5678);
        @(posedge clk);
        #1;
        check("basic_trace_drop", {31'd0, trace_valid}, 32'd0);
        check("basic_trace_hold_pc", trace_pc, 32'h0000_3000);

        // $0 protection
        @(negedge clk);
        we  = 1'b1;
        wa  = 5'd0;
        wd  = 32'hFFFF_FFFF;
        pc  = 32'h0000_3004;
        ra1 = 5'd0;
        ra2 = 5'd0;
        #1;
        check("zero_rd1_pre", rd1, 32'd0);
        check("zero_rd2_pre", rd2, 32'd0);
        @(posedge clk);
        #1;
        check("zero_rd1_post", rd1, 32'd0);
        check("zero_trace_valid", {31'd0, trace_valid}, 32'd0);
        check("zero_trace_hold_data", trace_data, 32'h1234_5678);

        // forwarding, both ports at once
        do_write(5'd5, 32'hAAAA_AAAA, 32'h0000_3008);
        @(negedge clk);
        we  = 1'b1;
        wa  = 5'd5;
        wd  = 32'h5555_5555;
        ra1 = 5'd5;
        ra2 = 5'd5;
        #1;
        check("fwd_rd1", rd1, 32'h5555_5555);
        check("fwd_rd2", rd2, 32'h5555_5555);
        check("nofwd_rd1", rd1_nf, 32'hAAAA_AAAA);
        check("nofwd_rd2", rd2_nf, 32'hAAAA_AAAA);
        @(posedge clk);
        model[5] = 32'h5555_5555;
        idle();
        #1;
        check("fwd_commit_rd1", rd1, 32'h5555_5555);

        // jal link into $31
        do_write(5'd31, 32'h0000_3008, 32'h0000_3004);
        idle();
        ra2 = 5'd31;
        #1;
        check("jal_rd2", rd2, 32'h0000_3008);
        for (int i = 1; i < 31; i++) begin
            ra1 = 5'(i);
            #1;
            check("jal_other_regs", rd1, model[i]);
        end

        // async reset between edges drops the pending write
        do_write(5'd12, 32'hDEAD_BEEF, 32'h0000_4000);
        idle();
        ra1 = 5'd12;
        #1;
        check("pre_rst_rd1", rd1, 32'hDEAD_BEEF);
        check("pre_rst_trace_valid", {31'd0, trace_valid}, 32'd1);
        we = 1'b1;
        wa = 5'd12;
        wd = 32'h1111_1111;
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rd1", rd1_nf, 32'd0);
        check("async_trace_valid", {31'd0, trace_valid}, 32'd0);
        check("async_trace_pc", trace_pc, 32'd0);
        check("async_trace_addr", {27'd0, trace_addr}, 32'd0);
        check("async_trace_data", trace_data, 32'd0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        idle();
        reset_n = 1'b1;
        #1;
        check("post_rst_rd1", rd1, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_rd1_edge", rd1, 32'd0);
        check("post_rst_trace_valid", {31'd0, trace_valid}, 32'd0);
        check("post_rst_rd2", rd2, model[31]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grf_wb.md
Name: grf_wb

Overview:
- 32 x 32-bit general register file for the single-cycle MIPS core. It is the consumer of the write-address and write-data selection paths.
- Accepts one write per clock: write address (rd / rt / 31) and write data (ALU / DM / PC+4), both already muxed upstream. Serves two combinational read ports to the ALU and the comparator.
- Register $0 is hardwired to zero. Same-cycle write-to-read forwarding is built in.
- Registers a one-cycle-delayed write-back trace record (pc, addr, data) for the grading/debug log.

Parameters:
- DW, 32, data width of every register
- AW, 5, address width; depth is 2**AW
- FWD_EN, 1, 1 = forward same-cycle write data to the read ports; 0 = read returns the stored value only

Ports:
- clk  input  1  core clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- ra1  input  AW  read address port 1 (instr rs)
- ra2  input  AW  read address port 2 (instr rt)
- rd1  output  DW  read data port 1, combinational
- rd2  output  DW  read data port 2, combinational
- we  input  1  write enable (RegWrite)
- wa  input  AW  write address, from the write-address selector
- wd  input  DW  write data, from the write-data selector
- pc  input  32  PC of the instruction currently writing back
- trace_valid  output  1  registered: a non-$0 write committed last cycle
- trace_pc  output  32  registered PC of that write
- trace_addr  output  AW  registered address of that write
- trace_data  output  DW  registered data of that write

Behaviour:
- Reset:
  - Asynchronous on reset_n low: all 2**AW registers clear to 0. trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0.
  - On reset_n rising, the first write can occur at the next rising clk.
  - Reset asserted mid-cycle clears everything immediately. The pending write is dropped.
- Write:
  - On rising clk with we=1 and wa!=0: reg[wa] <= wd. Latency 1 cycle.
  - Writes with wa==0 are discarded, so reg[0] is always 0.
  - we=0: no state change in the array.
- Read:
  - rdN = (raN==0) ? 0 : reg[raN], purely combinational, no clock latency.
- Forwarding (FWD_EN=1):
  - If we=1, wa!=0 and wa==raN in the same cycle, rdN=wd instead of the stored value.
  - The condition is evaluated independently for each port, so both ports may forward simultaneously (ra1==ra2==wa).
  - raN==0 always yields 0, even when wa==0 and wd!=0.
- Trace register:
  - Updates on every rising clk.
  - trace_valid <= we & (wa!=0).
  - trace_pc/addr/data load pc/wa/wd when that condition is true; otherwise they hold their previous values.
  - Consumers sample the trace fields only when trace_valid=1.
- Width rules:
  - No sign or zero extension inside the block.
  - pc is passed through unchanged. The trace holds pc, not pc+4.
- Boundary: address 2**AW-1 (31, the $ra target of jal) behaves like any other register. There is no wrap, since the address fully decodes the array.
- No X propagation: every register has a reset value. Outputs are defined from reset onward.

Test Plan:
- Reset then read all: hold reset_n=0, pulse clk, release, sweep ra1/ra2 0..31 -> rd1=rd2=0 for every address; trace_valid=0.
- Basic write/read: we=1, wa=8, wd=0x1234_5678, pc=0x3000 at edge N -> from edge N, ra1=8 gives rd1=0x1234_5678; after edge N, trace_valid=1, trace_pc=0x3000, trace_addr=8, trace_data=0x1234_5678; with we=0 at edge N+1 trace_valid returns to 0.
- $0 protection: we=1, wa=0, wd=0xFFFF_FFFF -> ra1=0 gives 0 both before and after the edge; trace_valid stays 0.
- Forwarding: reg[5]=0xAAAA_AAAA; same cycle we=1, wa=5, wd=0x5555_5555, ra1=ra2=5 -> rd1=rd2=0x5555_5555 before the edge (FWD_EN=1), and 0xAAAA_AAAA with FWD_EN=0.
- jal link: we=1, wa=31, wd=0x0000_3008 -> rd2 with ra2=31 reads 0x0000_3008 after the edge; registers 1..30 unchanged.
- Async reset mid-operation: write reg[12]=0xDEAD_BEEF, then drop reset_n between clock edges -> rd1 (ra1=12) goes to 0 without waiting for a clk edge; trace outputs go to 0 immediately.
